// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// in WIDTH iterations plus one sign-fixup cycle, and services MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               is_div, sa, sb;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Divide-by-zero keeps A raw and unsigned so the restoring loop naturally
  // yields quotient all-ones and remainder A.
  logic             b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    b_zero = (B == '0);
    a_neg  = ~op[0] & A[WIDTH-1] & ~(op[1] & b_zero);
    b_neg  = ~op[0] & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
  end

  logic [WIDTH:0]     mul_sum, div_sh, div_tr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh  = acc[2*WIDTH-1:WIDTH-1];
    div_tr  = div_sh - {1'b0, opnd};
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            sa     <= a_neg;
            sb     <= b_neg;
            cnt    <= '0;
            busy   <= 1'b1;
            // Divide: acc = {remainder, dividend}; multiply: acc = {partial, multiplier}
            opnd   <= op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div)
            acc <= div_tr[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          if (is_div) begin
            lo <= quo;
            hi <= rem;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected HI/LO from an
// arithmetic reference model, monitor checks each done pulse.
module tb_muldiv_unit;
  logic        clk = 0, rst = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0]  op = 0;
  logic [31:0] A = 0, B = 0, wdata = 0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          e0;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0, busy_cnt = 0;
  logic [63:0] cur_hilo = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {hi, lo} per MIPS semantics, from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sq, sr;
    logic [63:0] ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({"result_", e.name}, {hi, lo}, e.res);
          chk({"latency_", e.name}, 64'(cyc - e.e0), 64'd33);
          chk({"busy_len_", e.name}, 64'(busy_cnt), 64'd33);
          chk({"busy_at_done_", e.name}, 64'(busy), 64'd0);
          cur_hilo = e.res;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit with_hi, input logic [31:0] wd);
    wait_idle();
    op = o; A = a; B = b; start = 1;
    hi_we = with_hi; wdata = wd;
    q.push_back('{model(o, a, b), cyc + 1, $sformatf("op%0d_%h_%h", o, a, b)});
    @(negedge clk);
    if (with_hi) cur_hilo[63:32] = wd;
    start = 0; hi_we = 0;
    A = $urandom; B = $urandom; op = 2'($urandom);
  endtask

  initial begin
    int e0;
    int n;
    logic [31:0] a, b;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 0;
    @(negedge clk);

    // Abort MULTU 7*9 by reset mid-calculation
    op = 2'd1; A = 7; B = 9; start = 1; e0 = cyc + 1;
    @(negedge clk);
    start = 0;
    while (cyc < e0 + 10) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    busy_cnt = 0;
    cur_hilo = 0;
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_busy", 64'(busy), 64'd0);

    // Directed corner cases, issued back-to-back on the done cycle
    issue(2'd1, 32'd7, 32'd9, 0, 0);
    issue(2'd0, 32'hFFFFFFFD, 32'd5, 0, 0);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    issue(2'd3, 32'd100, 32'd7, 0, 0);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    issue(2'd3, 32'h12345678, 32'd0, 0, 0);
    issue(2'd2, 32'h87654321, 32'd0, 0, 0);
    issue(2'd0, 32'h80000000, 32'h80000000, 0, 0);

    // Start during busy is ignored; LO write during busy is ignored
    issue(2'd3, 32'd1000, 32'd3, 0, 0);
    repeat (5) @(negedge clk);
    op = 2'd0; A = 32'd5; B = 32'd6; start = 1;
    @(negedge clk);
    start = 0; lo_we = 1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    lo_we = 0;
    repeat (3) @(negedge clk);
    chk("lo_we_busy", {32'd0, lo}, {32'd0, cur_hilo[31:0]});

    // MTHI / MTLO in IDLE
    wait_idle();
    @(negedge clk);
    hi_we = 1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 0; cur_hilo[63:32] = 32'hA5A5A5A5;
    chk("mthi_idle", {hi, lo}, cur_hilo);
    lo_we = 1; wdata = 32'h0BADF00D;
    @(negedge clk);
    lo_we = 0; cur_hilo[31:0] = 32'h0BADF00D;
    chk("mtlo_idle", {hi, lo}, cur_hilo);

    // MTHI together with start: visible during the op, then overwritten
    issue(2'd1, 32'd3, 32'd4, 1, 32'h5A5A1234);
    chk("mthi_with_start", {hi, lo}, cur_hilo);
    repeat (25) @(negedge clk);
    chk("mthi_hold_busy", {hi, lo}, cur_hilo);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) b = 0;
      issue(2'($urandom_range(0, 3)), a, b, 0, 0);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
    @(negedge clk);
    chk("final_hilo", {hi, lo}, cur_hilo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU path cannot complete in one cycle.
- Owns the HI/LO architectural registers and services MTHI/MTLO writes.
- Talks to the pipeline control through a start/busy/done handshake; control stalls MFHI/MFLO and any new mul/div request while busy=1.

Parameters:
WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH. The counter is sized $clog2(WIDTH)+1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO hold new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and internal operand registers cleared. Reset mid-operation aborts the operation; HI/LO read 0 and no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch sign flags sa=A[31], sb=B[31] for signed ops; forced to 0 for unsigned ops.
  - Latch magnitudes |A| and |B| (two's-complement negate when the sign flag is set; 0x80000000 stays 0x80000000, treated as unsigned).
  - Clear counter and 2*WIDTH accumulator; busy<=1; state<=CALC.
- CALC: one iteration per edge, WIDTH edges (E1..E32), then state<=FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first; remainder register WIDTH+1 bits.
- FIX, edge E33:
  - Multiply: product negated (2*WIDTH-bit) if sa^sb; hi<=product[63:32], lo<=product[31:0].
  - Divide: lo<=quotient, negated if sa^sb; hi<=remainder, negated if sa (remainder takes the dividend's sign).
  - busy<=0; done<=1 for exactly one cycle; state<=IDLE.
- Latency: result visible, with done=1, in the 33rd cycle after the start edge; back-to-back start is accepted on the cycle done=1.
- Divide by zero, B==0 (sampled at E0): no trap. Result is lo=0xFFFFFFFF, hi=A (raw A, no sign fixup). Still 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap).
- start=1 while busy or in FIX: ignored; no queueing.
- hi_we/lo_we:
  - In IDLE: the register is written at the edge and the written value is visible next cycle.
  - Simultaneous with start in IDLE: write is applied, start is also accepted, and the mul/div result later overwrites both HI and LO.
  - While busy: ignored; HI/LO are not modified until FIX.
- hi and lo are stable at all times except at the IDLE write edge and the FIX edge.
- op is ignored when start=0; A, B and op may change freely after E0.

Test Plan:
- Reset mid-CALC: start MULTU 7*9, assert rst at E10 -> hi=lo=0, busy=0, done never pulses; then MULTU 7*9 -> lo=0x3F, hi=0 after 33 cycles.
- Signed multiply: MULT A=0xFFFFFFFD (-3), B=5 -> done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide signs: DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678, busy exactly 33 cycles.
- Handshake: pulse start during busy with different op/operands -> ignored, original result delivered; done is a single-cycle pulse; new start on the done cycle is accepted, busy stays 1 for the next 33 cycles.
- MTHI/MTLO: IDLE hi_we=1, wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle; lo_we during busy -> lo unchanged until FIX; hi_we with start at the same edge -> hi=wdata for 33 cycles, then the mul/div result.
